// File: rtl/multiplier_if.sv
// multiplier_if: start/finish handshake, operands, product and shared adder/comparator links.
interface multiplier_if #(parameter int N = 4);
    logic           i_start;
    logic           o_finished;
    logic [N-1:0]   i_multiplicand;
    logic [N-1:0]   i_multiplier;
    logic [2*N-1:0] o_product;
    logic [N-1:0]   o_adder_augend;
    logic [N-1:0]   o_adder_addend;
    logic [N-1:0]   i_adder_sum;
    logic           i_adder_carry;
    logic [N-1:0]   o_comparator_left;
    logic [N-1:0]   o_comparator_right;
    logic           i_comparator_equal;

    modport slave (
        input  i_start, i_multiplicand, i_multiplier, i_adder_sum, i_adder_carry, i_comparator_equal,
        output o_finished, o_product, o_adder_augend, o_adder_addend, o_comparator_left, o_comparator_right
    );

    modport master (
        output i_start, i_multiplicand, i_multiplier, i_adder_sum, i_adder_carry, i_comparator_equal,
        input  o_finished, o_product, o_adder_augend, o_adder_addend, o_comparator_left, o_comparator_right
    );
endinterface

// File: rtl/multiplier.sv
// multiplier: sequential unsigned shift-and-add multiplier borrowing the ALU's adder and comparator.
module multiplier #(parameter int N = 4) (
    input logic          i_clock,
    input logic          i_reset,
    multiplier_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

    localparam logic [N-1:0] STEPS = N[N-1:0];

    state_t         state_q;
    logic [2*N-1:0] p_q;
    logic [N-1:0]   m_q;
    logic [N-1:0]   cnt_q;
    logic           c_q;
    logic           fin_q;

    assign bus.o_finished = fin_q;
    assign bus.o_product  = p_q;

    // The step counter is incremented through the shared adder, so the adder serves both states.
    always_comb begin
        bus.o_adder_augend     = state_q == ADD ? p_q[2*N-1:N] : state_q == SHIFT ? cnt_q : '0;
        bus.o_adder_addend     = state_q == ADD ? (p_q[0] ? m_q : '0) : state_q == SHIFT ? N'(1) : '0;
        bus.o_comparator_left  = state_q == SHIFT ? bus.i_adder_sum : '0;
        bus.o_comparator_right = state_q == SHIFT ? STEPS : '0;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            p_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            case (state_q)
                ADD: begin
                    p_q[2*N-1:N] <= bus.i_adder_sum;
                    c_q          <= bus.i_adder_carry;
                    state_q      <= SHIFT;
                end
                SHIFT: begin
                    p_q     <= {c_q, p_q[2*N-1:1]};
                    cnt_q   <= bus.i_adder_sum;
                    state_q <= bus.i_comparator_equal ? DONE : ADD;
                    fin_q   <= bus.i_comparator_equal;
                end
                default: begin
                    if (bus.i_start) begin
                        m_q     <= bus.i_multiplicand;
                        p_q     <= {{N{1'b0}}, bus.i_multiplier};
                        cnt_q   <= '0;
                        c_q     <= 1'b0;
                        fin_q   <= 1'b0;
                        state_q <= ADD;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multiplier.sv
// tb_multiplier: randomized and directed checks of the N=4 and N=8 multipliers against M*Q.
module tb_multiplier;
    logic i_clock = 1'b0;
    logic i_reset = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 i_clock = ~i_clock;

    multiplier_if #(.N(4)) if4 ();
    multiplier_if #(.N(8)) if8 ();

    multiplier #(.N(4)) dut4 (.i_clock(i_clock), .i_reset(i_reset), .bus(if4));
    multiplier #(.N(8)) dut8 (.i_clock(i_clock), .i_reset(i_reset), .bus(if8));

    // Shared adder and comparator as the ALU would provide them.
    assign {if4.i_adder_carry, if4.i_adder_sum} = {1'b0, if4.o_adder_augend} + {1'b0, if4.o_adder_addend};
    assign if4.i_comparator_equal = if4.o_comparator_left == if4.o_comparator_right;
    assign {if8.i_adder_carry, if8.i_adder_sum} = {1'b0, if8.o_adder_augend} + {1'b0, if8.o_adder_addend};
    assign if8.i_comparator_equal = if8.o_comparator_left == if8.o_comparator_right;

    function automatic logic obs_fin(input bit wide);
        return wide ? if8.o_finished : if4.o_finished;
    endfunction

    function automatic logic [15:0] obs_prod(input bit wide);
        return wide ? if8.o_product : {8'h00, if4.o_product};
    endfunction

    function automatic logic [31:0] obs_shared(input bit wide);
        return wide ? {if8.o_adder_augend, if8.o_adder_addend, if8.o_comparator_left, if8.o_comparator_right}
                    : {16'h0, if4.o_adder_augend, if4.o_adder_addend, if4.o_comparator_left, if4.o_comparator_right};
    endfunction

    task automatic drive(input bit wide, input logic s, input logic [7:0] m, input logic [7:0] q);
        if (wide) begin
            if8.i_start = s; if8.i_multiplicand = m; if8.i_multiplier = q;
        end else begin
            if4.i_start = s; if4.i_multiplicand = m[3:0]; if4.i_multiplier = q[3:0];
        end
    endtask

    // One full operation: start, then expect o_finished exactly 2N edges later with the product M*Q.
    task automatic mul(input bit wide, input logic [7:0] m, input logic [7:0] q, input bit hold);
        int          n = wide ? 8 : 4;
        logic [15:0] exp_p = wide ? 16'(m) * 16'(q) : 16'(m[3:0]) * 16'(q[3:0]);
        @(negedge i_clock);
        drive(wide, 1'b1, m, q);
        for (int j = 0; j <= 2 * n; j++) begin
            if (j > 0) @(posedge i_clock); else @(posedge i_clock);
            #1;
            if (j == 0) drive(wide, hold, 8'($urandom), 8'($urandom));
            total_cnt++;
            if (obs_fin(wide) !== (j == 2 * n))
                $display("FAIL finished_timing N=%0d m=%0h q=%0h cycle=%0d got=%b want=%b", n, m, q, j, obs_fin(wide), j == 2 * n);
            else pass_cnt++;
        end
        total_cnt++;
        if (obs_prod(wide) !== exp_p)
            $display("FAIL product N=%0d m=%0h q=%0h got=%0h want=%0h", n, m, q, obs_prod(wide), exp_p);
        else pass_cnt++;
        total_cnt++;
        if (obs_shared(wide) !== 32'h0)
            $display("FAIL shared_idle N=%0d got=%0h want=0", n, obs_shared(wide));
        else pass_cnt++;
        @(negedge i_clock);
        drive(wide, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 8'h0, 8'h0);
        drive(1'b1, 1'b0, 8'h0, 8'h0);
        repeat (2) @(posedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b1;
        @(posedge i_clock);
        #1;
        total_cnt++;
        if ({obs_fin(1'b0), obs_prod(1'b0), obs_shared(1'b0), obs_fin(1'b1), obs_prod(1'b1), obs_shared(1'b1)} !== '0)
            $display("FAIL reset_state fin4=%b p4=%0h fin8=%b p8=%0h want all 0", obs_fin(1'b0), obs_prod(1'b0), obs_fin(1'b1), obs_prod(1'b1));
        else pass_cnt++;
    endtask

    task automatic test_directed();
        mul(1'b0, 8'd3, 8'd5, 1'b0);
        mul(1'b0, 8'd15, 8'd15, 1'b0);
        mul(1'b0, 8'd0, 8'd9, 1'b0);
        mul(1'b0, 8'd9, 8'd1, 1'b0);
    endtask

    task automatic test_back_to_back();
        mul(1'b0, 8'd2, 8'd3, 1'b0);
        mul(1'b0, 8'd7, 8'd6, 1'b0);
    endtask

    task automatic test_reset_mid();
        @(negedge i_clock);
        drive(1'b0, 1'b1, 8'd11, 8'd13);
        @(posedge i_clock);
        #1 drive(1'b0, 1'b0, 8'd0, 8'd0);
        repeat (3) @(posedge i_clock);
        #3 i_reset = 1'b0;
        #1;
        total_cnt++;
        if ({obs_fin(1'b0), obs_prod(1'b0), obs_shared(1'b0)} !== '0)
            $display("FAIL reset_mid fin=%b prod=%0h shared=%0h want 0", obs_fin(1'b0), obs_prod(1'b0), obs_shared(1'b0));
        else pass_cnt++;
        @(negedge i_clock);
        i_reset = 1'b1;
        repeat (12) @(posedge i_clock);
        #1;
        total_cnt++;
        if ({obs_fin(1'b0), obs_prod(1'b0)} !== '0)
            $display("FAIL reset_stays_idle fin=%b prod=%0h want 0", obs_fin(1'b0), obs_prod(1'b0));
        else pass_cnt++;
        mul(1'b0, 8'd11, 8'd13, 1'b0);
    endtask

    task automatic test_wide();
        mul(1'b1, 8'hFF, 8'hFF, 1'b1);
        mul(1'b1, 8'h80, 8'h03, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) mul(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        for (int i = 0; i < 6; i++) mul(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_wide();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
